// File: rtl/score_tally.sv
// score_tally: rhythm-game score keeper.
// Counts per-lane hit and miss rising edges while a song is in PLAY, keeps
// a saturating binary score (shown as 4 BCD digits one cycle later), a
// combo / max-combo pair and a judged-note counter that ends the song.
// Optional feature macro: SCORE_TALLY_COMBO_BONUS_EN -- doubles the points
// of every hit while the combo entering the cycle is 10 or more.
module score_tally #(
  parameter int NUM_NOTES = 32,
  parameter int POINTS    = 10
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [7:0]  keycode_second,
  input  logic [7:0]  score_in,
  input  logic [7:0]  miss_in,
  output logic [15:0] score_bcd,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [7:0]  judged,
  output logic [1:0]  state_out,
  output logic        hit_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  // Number of set bits in a lane vector (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Double-dabble conversion of a 0..9999 binary value to 4 BCD digits.
  function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
      if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
      if (sh[25:22] >= 4'd5) sh[25:22] = sh[25:22] + 4'd3;
      if (sh[29:26] >= 4'd5) sh[29:26] = sh[29:26] + 4'd3;
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  state_t      state_r, state_next_s;
  logic [7:0]  hit_hist_r, miss_hist_r;
  logic [13:0] score_bin_r;
  logic [15:0] score_bcd_r;
  logic [7:0]  combo_r, max_combo_r, judged_r;
  logic        hit_pulse_r;

  logic        quit_s, start_s, count_en_s, start_edge_s, song_over_s;
  logic [7:0]  hit_rise_s, miss_rise_s;
  logic [3:0]  h_s, m_s;
  logic [15:0] pts_s, add_s, score_sum_s;
  logic [13:0] score_next_s;
  logic [8:0]  combo_sum_s;
  logic [7:0]  combo_hit_s, combo_next_s, max_next_s, judged_next_s;
  logic [9:0]  judged_sum_s;

  assign quit_s       = (keycode == 8'h01) || (keycode_second == 8'h01);
  assign start_s      = (keycode == 8'h2c) || (keycode_second == 8'h2c);
  assign start_edge_s = (state_r == ST_IDLE) && start_s && !quit_s;
  assign count_en_s   = (state_r == ST_PLAY) && !quit_s;
  assign song_over_s  = ({24'd0, judged_r} >= 32'(NUM_NOTES));

  assign hit_rise_s  = score_in & ~hit_hist_r;
  assign miss_rise_s = miss_in & ~miss_hist_r;
  assign h_s         = popcount8(hit_rise_s);
  assign m_s         = popcount8(miss_rise_s);

  // Points per hit this cycle; the bonus looks at the combo entering the cycle.
  always_comb begin
    pts_s = 16'(POINTS);
`ifdef SCORE_TALLY_COMBO_BONUS_EN
    if (combo_r >= 8'd10) begin
      pts_s = 16'(2 * POINTS);
    end else begin
      pts_s = 16'(POINTS);
    end
`endif
  end

  // Next values of score, combo, max_combo and judged for a counting cycle.
  always_comb begin
    add_s       = 16'(h_s) * pts_s;
    score_sum_s = {2'b00, score_bin_r} + add_s;
    if (score_sum_s > {2'b00, SCORE_MAX}) begin
      score_next_s = SCORE_MAX;
    end else begin
      score_next_s = score_sum_s[13:0];
    end

    combo_sum_s = {1'b0, combo_r} + {5'd0, h_s};
    if (combo_sum_s > 9'd255) begin
      combo_hit_s = 8'd255;
    end else begin
      combo_hit_s = combo_sum_s[7:0];
    end

    // Hits land first (feeding max_combo), then any miss breaks the combo.
    if (combo_hit_s > max_combo_r) begin
      max_next_s = combo_hit_s;
    end else begin
      max_next_s = max_combo_r;
    end

    if (m_s != 4'd0) begin
      combo_next_s = 8'd0;
    end else begin
      combo_next_s = combo_hit_s;
    end

    judged_sum_s = {2'b00, judged_r} + {6'd0, h_s} + {6'd0, m_s};
    if (judged_sum_s > 10'd255) begin
      judged_next_s = 8'd255;
    end else begin
      judged_next_s = judged_sum_s[7:0];
    end
  end

  // Song state register.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; quit wins over start.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (quit_s) begin
          state_next_s = ST_IDLE;
        end else if (start_s) begin
          state_next_s = ST_PLAY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (quit_s) begin
          state_next_s = ST_IDLE;
        end else if (song_over_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (quit_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Edge-detect history follows the lane levels in every state.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      hit_hist_r  <= 8'd0;
      miss_hist_r <= 8'd0;
    end else begin
      hit_hist_r  <= score_in;
      miss_hist_r <= miss_in;
    end
  end

  // Song counters: cleared on start, updated in PLAY, held otherwise.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      score_bin_r <= 14'd0;
      score_bcd_r <= 16'h0000;
      combo_r     <= 8'd0;
      max_combo_r <= 8'd0;
      judged_r    <= 8'd0;
      hit_pulse_r <= 1'b0;
    end else if (start_edge_s) begin
      score_bin_r <= 14'd0;
      score_bcd_r <= 16'h0000;
      combo_r     <= 8'd0;
      max_combo_r <= 8'd0;
      judged_r    <= 8'd0;
      hit_pulse_r <= 1'b0;
    end else if (count_en_s) begin
      score_bin_r <= score_next_s;
      score_bcd_r <= bin_to_bcd(score_bin_r);
      combo_r     <= combo_next_s;
      max_combo_r <= max_next_s;
      judged_r    <= judged_next_s;
      hit_pulse_r <= (h_s != 4'd0);
    end else begin
      score_bcd_r <= bin_to_bcd(score_bin_r);
      hit_pulse_r <= 1'b0;
    end
  end

  assign score_bcd = score_bcd_r;
  assign combo     = combo_r;
  assign max_combo = max_combo_r;
  assign judged    = judged_r;
  assign state_out = state_r;
  assign hit_pulse = hit_pulse_r;

endmodule

// File: tb/tb_score_tally.sv
// Directed testbench for score_tally: one instance with an unreachable song
// length (long runs, saturation) and one with NUM_NOTES=4 (song end).
module tb_score_tally;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  keycode, keycode_second, score_in, miss_in;
  logic [15:0] score_bcd_a, score_bcd_b;
  logic [7:0]  combo_a, max_combo_a, judged_a;
  logic [7:0]  combo_b, max_combo_b, judged_b;
  logic [1:0]  state_a, state_b;
  logic        hit_pulse_a, hit_pulse_b;

  int checks = 0;
  int errors = 0;

`ifdef SCORE_TALLY_COMBO_BONUS_EN
  localparam logic [15:0] EXP_AFTER_11 = 16'h0120;
`else
  localparam logic [15:0] EXP_AFTER_11 = 16'h0110;
`endif

  score_tally #(.NUM_NOTES(1000), .POINTS(10)) dut_a (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode_second(keycode_second),
    .score_in(score_in), .miss_in(miss_in),
    .score_bcd(score_bcd_a), .combo(combo_a), .max_combo(max_combo_a),
    .judged(judged_a), .state_out(state_a), .hit_pulse(hit_pulse_a)
  );

  score_tally #(.NUM_NOTES(4), .POINTS(10)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode_second(keycode_second),
    .score_in(score_in), .miss_in(miss_in),
    .score_bcd(score_bcd_b), .combo(combo_b), .max_combo(max_combo_b),
    .judged(judged_b), .state_out(state_b), .hit_pulse(hit_pulse_b)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic start_song();
    keycode = 8'h01; tick(1);
    keycode = 8'h2c; tick(1);
    keycode = 8'h00;
  endtask

  task automatic single_hit_lane0();
    score_in = 8'h01; tick(1);
    score_in = 8'h00; tick(1);
  endtask

  task automatic test_reset();
    Reset = 1'b0; keycode = 8'h00; keycode_second = 8'h00;
    score_in = 8'h00; miss_in = 8'h00;
    tick(2);
    checks++; if (score_bcd_a !== 16'h0000) begin errors++; $display("FAIL reset_score got %h want 0000", score_bcd_a); end
    checks++; if (state_a !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state_a); end
    checks++; if ({combo_a, max_combo_a, judged_a} !== 24'd0) begin errors++; $display("FAIL reset_counters got %h want 0", {combo_a, max_combo_a, judged_a}); end
    Reset = 1'b1;
    tick(2);
    checks++; if (state_a !== 2'b00 || hit_pulse_a !== 1'b0) begin errors++; $display("FAIL reset_release state %b pulse %b want 00 0", state_a, hit_pulse_a); end
  endtask

  task automatic test_single_hit();
    int pulses;
    pulses = 0;
    start_song();
    checks++; if (state_a !== 2'b01) begin errors++; $display("FAIL start_state got %b want 01", state_a); end
    score_in = 8'h04;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (hit_pulse_a === 1'b1) pulses++;
    end
    checks++; if (score_bcd_a !== 16'h0010) begin errors++; $display("FAIL single_score got %h want 0010", score_bcd_a); end
    checks++; if (combo_a !== 8'd1 || judged_a !== 8'd1) begin errors++; $display("FAIL single_counts combo %0d judged %0d want 1 1", combo_a, judged_a); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
    score_in = 8'h00; tick(1);
  endtask

  task automatic test_simultaneous();
    int pulses;
    pulses = 0;
    start_song();
    score_in = 8'h0f;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (hit_pulse_a === 1'b1) pulses++;
    end
    checks++; if (score_bcd_a !== 16'h0040) begin errors++; $display("FAIL simul_score got %h want 0040", score_bcd_a); end
    checks++; if (combo_a !== 8'd4 || max_combo_a !== 8'd4) begin errors++; $display("FAIL simul_combo combo %0d max %0d want 4 4", combo_a, max_combo_a); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL simul_pulses got %0d want 1", pulses); end
    score_in = 8'h00; tick(1);
  endtask

  task automatic test_hit_miss();
    start_song();
    for (int i = 0; i < 3; i++) single_hit_lane0();
    checks++; if (combo_a !== 8'd3) begin errors++; $display("FAIL hm_pre_combo got %0d want 3", combo_a); end
    score_in = 8'h01; miss_in = 8'h02; tick(1);
    score_in = 8'h00; miss_in = 8'h00; tick(2);
    checks++; if (score_bcd_a !== 16'h0040) begin errors++; $display("FAIL hm_score got %h want 0040", score_bcd_a); end
    checks++; if (max_combo_a !== 8'd4 || combo_a !== 8'd0) begin errors++; $display("FAIL hm_combo max %0d combo %0d want 4 0", max_combo_a, combo_a); end
    checks++; if (judged_a !== 8'd5) begin errors++; $display("FAIL hm_judged got %0d want 5", judged_a); end
  endtask

  task automatic test_idle_ignore();
    keycode = 8'h01; tick(1);
    keycode = 8'h00;
    score_in = 8'hff; miss_in = 8'hff; tick(2);
    checks++; if (judged_a !== 8'd5 || score_bcd_a !== 16'h0040 || state_a !== 2'b00) begin errors++; $display("FAIL idle_hold judged %0d score %h state %b want 5 0040 00", judged_a, score_bcd_a, state_a); end
    keycode = 8'h01; keycode_second = 8'h2c; tick(1);
    checks++; if (state_a !== 2'b00) begin errors++; $display("FAIL quit_priority got %b want 00", state_a); end
    keycode = 8'h00; tick(1);
    checks++; if (state_a !== 2'b01 || judged_a !== 8'd0) begin errors++; $display("FAIL start_second state %b judged %0d want 01 0", state_a, judged_a); end
    keycode_second = 8'h00; tick(3);
    checks++; if (judged_a !== 8'd0 || combo_a !== 8'd0) begin errors++; $display("FAIL held_levels judged %0d combo %0d want 0 0", judged_a, combo_a); end
    score_in = 8'h00; miss_in = 8'h00; tick(1);
  endtask

  task automatic test_saturation();
    start_song();
    for (int i = 0; i < 1100; i++) begin
      single_hit_lane0();
      if (i == 9) begin
        checks++; if (score_bcd_a !== 16'h0100) begin errors++; $display("FAIL score_after_10 got %h want 0100", score_bcd_a); end
      end
      if (i == 10) begin
        checks++; if (score_bcd_a !== EXP_AFTER_11) begin errors++; $display("FAIL score_after_11 got %h want %h", score_bcd_a, EXP_AFTER_11); end
      end
    end
    checks++; if (score_bcd_a !== 16'h9999) begin errors++; $display("FAIL sat_score got %h want 9999", score_bcd_a); end
    checks++; if (combo_a !== 8'd255 || max_combo_a !== 8'd255 || judged_a !== 8'd255) begin errors++; $display("FAIL sat_counts combo %0d max %0d judged %0d want 255", combo_a, max_combo_a, judged_a); end
    for (int i = 0; i < 3; i++) single_hit_lane0();
    checks++; if (score_bcd_a !== 16'h9999) begin errors++; $display("FAIL sat_hold got %h want 9999", score_bcd_a); end
  endtask

  task automatic test_end_restart();
    start_song();
    for (int i = 0; i < 3; i++) single_hit_lane0();
    score_in = 8'h01; tick(1);
    checks++; if (state_b !== 2'b01 || judged_b !== 8'd4) begin errors++; $display("FAIL end_pre state %b judged %0d want 01 4", state_b, judged_b); end
    score_in = 8'h00; tick(1);
    checks++; if (state_b !== 2'b10) begin errors++; $display("FAIL end_state got %b want 10", state_b); end
    single_hit_lane0();
    checks++; if (judged_b !== 8'd4 || combo_b !== 8'd4 || score_bcd_b !== 16'h0040) begin errors++; $display("FAIL done_frozen judged %0d combo %0d score %h want 4 4 0040", judged_b, combo_b, score_bcd_b); end
    keycode = 8'h01; tick(1);
    checks++; if (state_b !== 2'b00 || judged_b !== 8'd4) begin errors++; $display("FAIL quit_hold state %b judged %0d want 00 4", state_b, judged_b); end
    keycode = 8'h2c; tick(1);
    keycode = 8'h00;
    checks++; if (state_b !== 2'b01 || {combo_b, max_combo_b, judged_b} !== 24'd0 || score_bcd_b !== 16'h0000) begin errors++; $display("FAIL restart_clear state %b counters %h score %h want 01 0 0000", state_b, {combo_b, max_combo_b, judged_b}, score_bcd_b); end
  endtask

  task automatic test_async_reset();
    start_song();
    single_hit_lane0();
    tick(1);
    checks++; if (score_bcd_a !== 16'h0010 || state_a !== 2'b01) begin errors++; $display("FAIL ar_pre score %h state %b want 0010 01", score_bcd_a, state_a); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (score_bcd_a !== 16'h0000 || state_a !== 2'b00 || hit_pulse_a !== 1'b0) begin errors++; $display("FAIL ar_now score %h state %b pulse %b want 0000 00 0", score_bcd_a, state_a, hit_pulse_a); end
    checks++; if ({combo_a, max_combo_a, judged_a} !== 24'd0) begin errors++; $display("FAIL ar_counters got %h want 0", {combo_a, max_combo_a, judged_a}); end
    tick(1);
    Reset = 1'b1;
    tick(2);
    checks++; if (state_a !== 2'b00 || judged_a !== 8'd0) begin errors++; $display("FAIL ar_release state %b judged %0d want 00 0", state_a, judged_a); end
  endtask

  initial begin
    Reset = 1'b0; keycode = 8'h00; keycode_second = 8'h00;
    score_in = 8'h00; miss_in = 8'h00;
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_hit_miss();
    test_idle_ignore();
    test_saturation();
    test_end_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
